// File: rtl/wb_intctrl_pkg.sv
// Shared register map and bit positions for the Wishbone interrupt controller.
package wb_intctrl_pkg;
  localparam logic ADDR_CTRL  = 1'b0;
  localparam logic ADDR_MODE  = 1'b1;
  localparam int   BIT_MASTER = 31;
  localparam int   BIT_ANY    = 15;
  localparam int   ENABLE_LSB = 16;
  localparam int   NINT_MAX   = 15;
endpackage

// File: rtl/intc_edge.sv
// Per-source capture: sync register, delay register and edge/level pending latch.
module intc_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode,
  input  logic clr,
  output logic pending
);
  logic r_irq;
  logic r_irq_d;
  logic set;

  // Set wins over a simultaneous software clear
  assign set = mode ? (r_irq & ~r_irq_d) : r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq   <= 1'b0;
      r_irq_d <= 1'b0;
      pending <= 1'b0;
    end else begin
      r_irq   <= irq;
      r_irq_d <= r_irq;
      pending <= set | (pending & ~clr);
    end
  end
endmodule

// File: rtl/wb_intctrl.sv
// Wishbone interrupt controller: CTRL (enables/pending/master) and MODE registers.
module wb_intctrl
  import wb_intctrl_pkg::*;
#(
  parameter int              NINT         = 15,
  parameter logic [NINT-1:0] DEFAULT_MODE = '1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic            i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic            o_wb_ack,
  output logic            o_wb_stall,
  output logic [31:0]     o_wb_data,
  input  logic [NINT-1:0] i_irq,
  output logic            o_int
);
  logic [NINT-1:0]     pending;
  logic [NINT-1:0]     enable;
  logic [NINT-1:0]     mode;
  logic [NINT-1:0]     clr;
  logic [NINT_MAX-1:0] pend_w;
  logic [NINT_MAX-1:0] en_w;
  logic                master_en;
  logic                any;
  logic                ack_q;
  logic                strobe;
  logic                wr_ctrl;
  logic                wr_mode;
  logic [31:0]         rdata;

  assign strobe  = i_wb_cyc & i_wb_stb;
  assign wr_ctrl = strobe & i_wb_we & (i_wb_addr == ADDR_CTRL);
  assign wr_mode = strobe & i_wb_we & (i_wb_addr == ADDR_MODE);
  assign clr     = wr_ctrl ? i_wb_data[NINT-1:0] : '0;
  assign any     = |(pending & enable);
  assign pend_w  = NINT_MAX'(pending);
  assign en_w    = NINT_MAX'(enable);

  for (genvar i = 0; i < NINT; i++) begin : g_src
    intc_edge u_src (
      .clk     (i_clk),
      .reset   (i_reset),
      .irq     (i_irq[i]),
      .mode    (mode[i]),
      .clr     (clr[i]),
      .pending (pending[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (i_wb_addr == ADDR_MODE)
      rdata[NINT-1:0] = mode;
    else
      rdata = {master_en, en_w, any, pend_w};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      master_en <= 1'b0;
      enable    <= '0;
      mode      <= DEFAULT_MODE;
      o_int     <= 1'b0;
      ack_q     <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_int <= master_en & any;
      ack_q <= strobe;
      if (strobe)
        o_wb_data <= rdata;
      if (wr_mode)
        mode <= i_wb_data[NINT-1:0];
      if (wr_ctrl) begin
        if (i_wb_data[BIT_ANY])
          master_en <= i_wb_data[BIT_MASTER];
        // Only selected enables take the new value
        for (int i = 0; i < NINT; i++)
          if (i_wb_data[ENABLE_LSB+i])
            enable[i] <= i_wb_data[BIT_MASTER];
      end
    end
  end

  assign o_wb_ack   = ack_q & i_wb_cyc;
  assign o_wb_stall = 1'b0;
endmodule

// File: tb/tb_wb_intctrl.sv
// Self-checking bench: directed scenarios then random traffic against a model.
module tb_wb_intctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, addr;
  logic [31:0] wdata;
  logic [14:0] irq;
  logic        ack, stall, cpu_int;
  logic [31:0] rdat;
  logic        ack4, stall4, cpu_int4;
  logic [31:0] rdat4;

  int checks = 0;
  int failures = 0;

  logic [14:0] m_pend, m_en, m_mode, s0, s1;
  logic        m_master, exp_int, exp_ack;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  wb_intctrl dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
    .i_irq(irq), .o_int(cpu_int)
  );

  wb_intctrl #(.NINT(4), .DEFAULT_MODE(4'b1010)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack4), .o_wb_stall(stall4), .o_wb_data(rdat4),
    .i_irq(irq[3:0]), .o_int(cpu_int4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_ctrl();
    return {m_master, m_en, |(m_pend & m_en), m_pend};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_master = 1'b0; m_mode = 15'h7FFF;
    s0 = '0; s1 = '0;
    exp_int = 1'b0; exp_ack = 1'b0; exp_data = '0;
  endtask

  // One rising edge of the specified behaviour, using pre-edge state
  task automatic tick();
    logic [14:0] set, clr;
    exp_int = m_master & (|(m_pend & m_en));
    exp_ack = cyc & stb;
    if (cyc & stb)
      exp_data = addr ? {17'd0, m_mode} : model_ctrl();
    for (int i = 0; i < 15; i++)
      set[i] = m_mode[i] ? (s0[i] & ~s1[i]) : s0[i];
    clr = (cyc & stb & we & ~addr) ? wdata[14:0] : 15'd0;
    m_pend = set | (m_pend & ~clr);
    if (cyc & stb & we) begin
      if (addr) m_mode = wdata[14:0];
      else begin
        if (wdata[15]) m_master = wdata[31];
        for (int i = 0; i < 15; i++)
          if (wdata[16+i]) m_en[i] = wdata[31];
      end
    end
    s1 = s0;
    s0 = irq;
  endtask

  task automatic step();
    @(posedge clk);
    tick();
    @(negedge clk);
    chk("o_int", 32'(cpu_int), 32'(exp_int));
    chk("o_wb_ack", 32'(ack), 32'(exp_ack));
    if (exp_ack) chk("o_wb_data", rdat, exp_data);
  endtask

  task automatic wb_write(input logic a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; addr = a; wdata = d;
    step();
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic a);
    cyc = 1; stb = 1; we = 0; addr = a;
    step();
    cyc = 0; stb = 0;
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; addr = 0; wdata = '0; irq = '0;
    model_reset();
    @(negedge clk);
    chk("rst_int", 32'(cpu_int), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", rdat, 0);
    rst = 0;
    wb_read(1);
    chk("rst_mode", rdat, 32'h7FFF);
    chk("rst_mode4", rdat4, 32'hA);

    // Scenario 1
    wb_write(0, 32'h8001_8000);
    irq = 15'h1;
    step();
    irq = '0;
    step();
    step();
    chk("s1_int", 32'(cpu_int), 1);
    wb_read(0);
    chk("s1_ctrl", rdat, 32'h8001_8001);

    // Scenario 2
    wb_write(0, 32'h1);
    step();
    chk("s2_int_fall", 32'(cpu_int), 0);
    irq = 15'h1;
    step();
    irq = '0;
    wb_write(0, 32'h1);
    wb_read(0);
    chk("s2_keep", 32'(rdat[0]), 1);

    // Scenario 3
    wb_write(1, 32'h0);
    irq = 15'h4;
    step(); step(); step();
    wb_write(0, 32'h4);
    wb_read(0);
    chk("s3_reset", 32'(rdat[2]), 1);
    irq = '0;
    step(); step();
    wb_write(0, 32'h4);
    wb_read(0);
    chk("s3_clear", 32'(rdat[2]), 0);

    // Scenario 4
    wb_write(1, 32'h7FFF);
    wb_write(0, 32'hFFFF_0000);
    wb_write(0, 32'h0000_8000);
    wb_write(0, 32'h0000_7FFF);
    step();
    irq = 15'h7FFF;
    step();
    irq = '0;
    step(); step();
    chk("s4_int_off", 32'(cpu_int), 0);
    wb_read(0);
    chk("s4_ctrl", rdat, 32'h7FFF_FFFF);
    wb_write(0, 32'h8000_8000);
    step();
    chk("s4_int_on", 32'(cpu_int), 1);

    // Scenario 5
    wb_write(0, 32'h0004_0000);
    wb_read(0);
    chk("s5_ctrl", rdat, 32'hFFFB_FFFF);
    wb_read(1);
    chk("s5_mode", rdat, 32'h7FFF);
    chk("s5_mode4", rdat4, 32'hF);

    // Scenario 6
    cyc = 1; stb = 1; we = 1; addr = 0; wdata = 32'h0000_7FFF;
    irq = 15'h2;
    #2 rst = 1;
    #1;
    chk("s6_ack", 32'(ack), 0);
    chk("s6_int", 32'(cpu_int), 0);
    chk("s6_data", rdat, 0);
    @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    rst = 0;
    model_reset();
    step(); step();
    wb_read(0);
    chk("s6_pend1", rdat, 32'h2);
    wb_read(1);
    chk("s6_mode", rdat, 32'h7FFF);
    chk("s6_mode4", rdat4, 32'hA);
    irq = '0;

    // Random traffic, including back-to-back strobes
    for (int n = 0; n < 400; n++) begin
      int op;
      irq = 15'($urandom & $urandom & $urandom);
      op = $urandom_range(0, 5);
      cyc = (op != 0);
      stb = (op != 1) && (op != 0);
      we = (op >= 3);
      addr = (op == 5) ? 1'b1 : ((op == 2) ? 1'($urandom) : 1'b0);
      wdata = $urandom;
      step();
    end
    cyc = 0; stb = 0; we = 0; irq = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
